// File: rtl/rx_linestate_ctrl.sv
// rtl/rx_linestate_ctrl.sv - full-speed receive line-state sampler with SYNC/DATA/EOP framing
// Optional SE0 bus-reset detector is built when RX_BUS_RESET_DET_EN is defined.
module rx_linestate_ctrl #(
   parameter int SE0_RST_CYC  = 120,
   parameter int SYNC_MIN_ALT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_dp,
   input  logic       line_dm,
   input  logic       rx_en,
   output logic [1:0] line_state,
   output logic       rx_active,
   output logic       rx_bit_vld,
   output logic       rx_bit,
   output logic       eop_det,
   output logic       rx_err,
   output logic       bus_reset
);

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_e;

   logic [1:0] line_state_q, line_state_d;
   logic [1:0] phase_q, phase_d;
   logic       strobe;
   state_e     state_q, state_d;
   logic [2:0] alt_cnt_q, alt_cnt_d;
   logic       prev_j_q, prev_j_d;
   logic [2:0] se0_cnt_q, se0_cnt_d;
   logic       rx_active_q, rx_active_d;
   logic       rx_bit_vld_q, rx_bit_vld_d;
   logic       rx_bit_q, rx_bit_d;
   logic       eop_det_q, eop_det_d;
   logic       rx_err_q, rx_err_d;
   logic       samp_j, samp_k, samp_se0;

   // Phase restarts on every line transition so the strobe lands mid-bit.
   assign line_state_d = {line_dm, line_dp};
   assign phase_d      = (line_state_d != line_state_q) ? 2'd0 : phase_q + 2'd1;
   assign strobe       = (phase_q == 2'd1);

   assign samp_j   = (line_state_q == LS_J);
   assign samp_k   = (line_state_q == LS_K);
   assign samp_se0 = (line_state_q == LS_SE0);

   always_comb begin
      state_d      = state_q;
      alt_cnt_d    = alt_cnt_q;
      prev_j_d     = prev_j_q;
      se0_cnt_d    = se0_cnt_q;
      rx_active_d  = rx_active_q;
      rx_bit_vld_d = 1'b0;
      rx_bit_d     = rx_bit_q;
      eop_det_d    = 1'b0;
      rx_err_d     = 1'b0;
      if (!rx_en) begin
         state_d     = ST_IDLE;
         rx_active_d = 1'b0;
      end else if (strobe) begin
         case (state_q)
            ST_IDLE: begin
               if (samp_k) begin
                  state_d   = ST_SYNC;
                  alt_cnt_d = 3'd0;
                  prev_j_d  = 1'b0;
               end
            end
            ST_SYNC: begin
               if (samp_j || samp_k) begin
                  if (samp_j != prev_j_q) begin
                     prev_j_d = samp_j;
                     if (alt_cnt_q != 3'd7) alt_cnt_d = alt_cnt_q + 3'd1;
                  end else if (samp_k && (int'(alt_cnt_q) >= SYNC_MIN_ALT)) begin
                     state_d     = ST_DATA;
                     rx_active_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d  = ST_IDLE;
                  rx_err_d = 1'b1;
               end
            end
            ST_DATA: begin
               if (samp_j || samp_k) begin
                  rx_bit_vld_d = 1'b1;
                  rx_bit_d     = samp_j;
               end else if (samp_se0) begin
                  state_d   = ST_EOP;
                  se0_cnt_d = 3'd1;
               end else begin
                  state_d     = ST_IDLE;
                  rx_active_d = 1'b0;
                  rx_err_d    = 1'b1;
               end
            end
            ST_EOP: begin
               if (samp_se0) begin
                  se0_cnt_d = se0_cnt_q + 3'd1;
                  // Fourth SE0 sample means the EOP is too long.
                  if (se0_cnt_q == 3'd3) begin
                     state_d     = ST_IDLE;
                     rx_active_d = 1'b0;
                     rx_err_d    = 1'b1;
                  end
               end else if (samp_j) begin
                  state_d     = ST_IDLE;
                  rx_active_d = 1'b0;
                  eop_det_d   = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  rx_active_d = 1'b0;
                  rx_err_d    = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_state_q <= LS_J;
         phase_q      <= 2'd0;
         state_q      <= ST_IDLE;
         alt_cnt_q    <= 3'd0;
         prev_j_q     <= 1'b0;
         se0_cnt_q    <= 3'd0;
         rx_active_q  <= 1'b0;
         rx_bit_vld_q <= 1'b0;
         rx_bit_q     <= 1'b0;
         eop_det_q    <= 1'b0;
         rx_err_q     <= 1'b0;
      end else begin
         line_state_q <= line_state_d;
         phase_q      <= phase_d;
         state_q      <= state_d;
         alt_cnt_q    <= alt_cnt_d;
         prev_j_q     <= prev_j_d;
         se0_cnt_q    <= se0_cnt_d;
         rx_active_q  <= rx_active_d;
         rx_bit_vld_q <= rx_bit_vld_d;
         rx_bit_q     <= rx_bit_d;
         eop_det_q    <= eop_det_d;
         rx_err_q     <= rx_err_d;
      end
   end

   assign line_state = line_state_q;
   assign rx_active  = rx_active_q;
   assign rx_bit_vld = rx_bit_vld_q;
   assign rx_bit     = rx_bit_q;
   assign eop_det    = eop_det_q;
   assign rx_err     = rx_err_q;

`ifdef RX_BUS_RESET_DET_EN
   localparam int SE0_CW = $clog2(SE0_RST_CYC + 1);
   localparam logic [SE0_CW-1:0] SE0_MAX = SE0_CW'(SE0_RST_CYC);

   logic [SE0_CW-1:0] se0_run_q, se0_run_d;

   // Runs off line_state alone so it keeps working while the link transmits.
   always_comb begin
      se0_run_d = se0_run_q;
      if (line_state_q != LS_SE0) se0_run_d = '0;
      else if (se0_run_q != SE0_MAX) se0_run_d = se0_run_q + SE0_CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) se0_run_q <= '0;
      else        se0_run_q <= se0_run_d;
   end

   assign bus_reset = (se0_run_q == SE0_MAX);
`else
   assign bus_reset = 1'b0;
`endif

endmodule
